lfsr_range_sampler: RTL and testbench

- Downstream consumer of the 16-bit free-running LFSR word (`rnd`).
- Converts raw pseudo-random words into uniformly distributed values in [0, cfg_limit) using mask-and-reject sampling.
- Buffers accepted samples in a small FIFO and presents them on a valid/ready output.
- Flags a stuck/locked-up generator.

---
 rtl/lfsr_range_sampler.sv | 162 ++++++++++++++++
 tb/tb_lfsr_range_sampler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_range_sampler.sv
// Mask-and-reject range sampler for a free-running LFSR word, with an output FIFO and lockup detection.
// Optional accept/reject statistics counters are built when LFSR_SAMPLER_STATS_EN is defined.
module lfsr_range_sampler #(
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int STUCK_CYCLES = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             rnd,
    input  logic                          rnd_valid,
    input  logic [DATA_W-1:0]             cfg_limit,
    input  logic                          cfg_load,
    output logic                          cfg_busy,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow_drop,
    output logic                          stuck
`ifdef LFSR_SAMPLER_STATS_EN
    ,
    output logic [31:0]                   accept_cnt,
    output logic [31:0]                   reject_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(STUCK_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] limit_q, mask_q;
    logic [DATA_W-1:0] candidate;
    logic              accept, evaluate, push, pop, full, do_push;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_q;

    logic [RW-1:0]     run_cnt_q, run_cnt_d;
    logic [DATA_W-1:0] prev_rnd;

    // Smear (limit-1) rightwards: yields the smallest 2^k-1 covering every value below limit.
    // limit==0 wraps to all ones, limit==1 gives zero.
    function automatic logic [DATA_W-1:0] mask_for(input logic [DATA_W-1:0] lim);
        logic [DATA_W-1:0] v;
        v = lim - DATA_W'(1);
        for (int s = 1; s < DATA_W; s = s * 2) begin
            v = v | (v >> s);
        end
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cfg_load) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (cfg_load) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_LOAD) begin
                limit_q <= cfg_limit;
                mask_q  <= mask_for(cfg_limit);
            end
        end
    end

    assign cfg_busy  = (state_q == ST_LOAD);
    assign candidate = rnd & mask_q;
    assign accept    = (limit_q == '0) || (candidate < limit_q);
    // A sample arriving alongside cfg_load belongs to the old configuration and is dropped.
    assign evaluate  = (state_q == ST_RUN) && rnd_valid && !cfg_load;
    assign push      = evaluate && accept;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign do_push   = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            overflow_drop <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            overflow_drop <= 1'b0;
        end else begin
            overflow_drop <= push && full && !pop;
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked by count_q and
    // out_data is forced to zero while empty, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= candidate;
    end

    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count_q;

    // Run length of identical consecutive words; zero means no previous word since LOAD/reset.
    always_comb begin
        run_cnt_d = RW'(1);
        if (run_cnt_q != '0 && rnd == prev_rnd) begin
            run_cnt_d = (run_cnt_q == RW'(STUCK_CYCLES)) ? run_cnt_q : run_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            run_cnt_q <= '0;
            prev_rnd  <= '0;
            stuck     <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            run_cnt_q <= '0;
            stuck     <= 1'b0;
        end else if (state_q == ST_RUN && rnd_valid) begin
            run_cnt_q <= run_cnt_d;
            prev_rnd  <= rnd;
            if (run_cnt_d == RW'(STUCK_CYCLES)) stuck <= 1'b1;
        end
    end

`ifdef LFSR_SAMPLER_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset || state_q == ST_LOAD) begin
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else if (evaluate) begin
            if (accept && accept_cnt != '1)  accept_cnt <= accept_cnt + 32'd1;
            if (!accept && reject_cnt != '1) reject_cnt <= reject_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Self-checking bench for lfsr_range_sampler: directed scenarios plus randomized traffic against a queue model.
// Define LFSR_SAMPLER_STATS_EN to also check the statistics counters.
module tb_lfsr_range_sampler;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int STK   = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] rnd;
    logic          rnd_valid;
    logic [DW-1:0] cfg_limit;
    logic          cfg_load;
    logic          cfg_busy;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    fifo_count;
    logic          overflow_drop;
    logic          stuck;
`ifdef LFSR_SAMPLER_STATS_EN
    logic [31:0]   accept_cnt;
    logic [31:0]   reject_cnt;
`endif

    always #5 clock = ~clock;

    lfsr_range_sampler #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .STUCK_CYCLES(STK)) dut (
        .clock         (clock),
        .reset         (reset),
        .rnd           (rnd),
        .rnd_valid     (rnd_valid),
        .cfg_limit     (cfg_limit),
        .cfg_load      (cfg_load),
        .cfg_busy      (cfg_busy),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_count    (fifo_count),
        .overflow_drop (overflow_drop),
        .stuck         (stuck)
`ifdef LFSR_SAMPLER_STATS_EN
        ,
        .accept_cnt    (accept_cnt),
        .reject_cnt    (reject_cnt)
`endif
    );

    typedef enum int {M_IDLE, M_LOAD, M_RUN} mstate_t;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] q[$];
    mstate_t       m_state = M_IDLE;
    int            m_lim = 65536;
    bit            m_stuck = 1'b0;
    int            m_run = 0;
    logic [DW-1:0] m_prev = '0;
    bit            m_drop = 1'b0;
    longint        m_acc = 0;
    longint        m_rej = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: bound is an integer 1..65536, mask is grown until it covers bound-1.
    task automatic model_step();
        int  sz0;
        bit  do_pop;
        int  mask;
        int  cand;
        m_drop = 1'b0;
        if (!reset) begin
            m_state = M_IDLE;
            q.delete();
            m_stuck = 1'b0;
            m_run   = 0;
            m_acc   = 0;
            m_rej   = 0;
            return;
        end
        sz0    = q.size();
        do_pop = (sz0 > 0) && out_ready;
        case (m_state)
            M_IDLE: begin
                if (do_pop) void'(q.pop_front());
                if (cfg_load) m_state = M_LOAD;
            end
            M_LOAD: begin
                m_lim   = (cfg_limit == 0) ? 65536 : int'(cfg_limit);
                q.delete();
                m_stuck = 1'b0;
                m_run   = 0;
                m_acc   = 0;
                m_rej   = 0;
                m_state = M_RUN;
            end
            default: begin
                if (rnd_valid) begin
                    if (m_run > 0 && rnd == m_prev) m_run = (m_run < STK) ? m_run + 1 : m_run;
                    else                            m_run = 1;
                    m_prev = rnd;
                    if (m_run >= STK) m_stuck = 1'b1;
                end
                if (do_pop) void'(q.pop_front());
                if (rnd_valid && !cfg_load) begin
                    mask = 0;
                    while (mask < m_lim - 1) mask = mask * 2 + 1;
                    cand = int'(rnd) & mask;
                    if (cand < m_lim) begin
                        if (m_acc < 64'hFFFF_FFFF) m_acc++;
                        if (sz0 == DEPTH && !do_pop) m_drop = 1'b1;
                        else                         q.push_back(cand[DW-1:0]);
                    end else begin
                        if (m_rej < 64'hFFFF_FFFF) m_rej++;
                    end
                end
                if (cfg_load) m_state = M_LOAD;
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [DW-1:0] head;
        head = (q.size() > 0) ? q[0] : '0;
        check("out_valid",     32'(out_valid),     32'(q.size() != 0));
        check("out_data",      32'(out_data),      32'(head));
        check("fifo_count",    32'(fifo_count),    32'(q.size()));
        check("overflow_drop", 32'(overflow_drop), 32'(m_drop));
        check("stuck",         32'(stuck),         32'(m_stuck));
        check("cfg_busy",      32'(cfg_busy),      32'(m_state == M_LOAD));
`ifdef LFSR_SAMPLER_STATS_EN
        check("accept_cnt",    accept_cnt,         m_acc[31:0]);
        check("reject_cnt",    reject_cnt,         m_rej[31:0]);
`endif
    endtask

    // Inputs are driven just after a falling edge; outputs are checked at the next falling edge.
    task automatic cycle(input logic rst, input logic ld, input logic [DW-1:0] r,
                         input logic v, input logic rdy);
        reset     = rst;
        cfg_load  = ld;
        rnd       = r;
        rnd_valid = v;
        out_ready = rdy;
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic load(input logic [DW-1:0] lim);
        cfg_limit = lim;
        cycle(1'b1, 1'b1, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        cfg_limit = '0;

        // Reset state
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
        check("rst_out_data", 32'(out_data), 32'h0);

        // Limit 10 -> mask 0x000F: 3 accepted, 0xF rejected, 0x29 -> 9
        load(16'd10);
        cycle(1'b1, 1'b0, 16'h0003, 1'b1, 1'b1);
        check("lim10_first", 32'(out_data), 32'h3);
        cycle(1'b1, 1'b0, 16'h000F, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 16'h0029, 1'b1, 1'b1);
        check("lim10_second", 32'(out_data), 32'h9);
`ifdef LFSR_SAMPLER_STATS_EN
        check("lim10_acc", accept_cnt, 32'd2);
        check("lim10_rej", reject_cnt, 32'd1);
`endif
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Limit 0 passes words through unchanged
        load(16'd0);
        cycle(1'b1, 1'b0, 16'hACE1, 1'b1, 1'b1);
        check("lim0_a", 32'(out_data), 32'hACE1);
        cycle(1'b1, 1'b0, 16'h5670, 1'b1, 1'b1);
        check("lim0_b", 32'(out_data), 32'h5670);

        // Limit 1 always yields zero
        load(16'd1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 16'($urandom_range(0, 65535)), 1'b1, 1'b1);
            check("lim1_zero", 32'(out_data), 32'h0);
        end

        // Fill, overflow by one, then drain in order
        load(16'd0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'(i * 16'h1111 + 1), 1'b1, 1'b0);
        check("fill_count", 32'(fifo_count), 32'd8);
        cycle(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
        check("fill_drop", 32'(overflow_drop), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
            check("drain_order", 32'(out_data), (i < 7) ? 32'((i + 1) * 16'h1111 + 1) : 32'h0);
        end

        // Full FIFO with simultaneous push and pop: no drop, count stays full
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'(16'h2000 + i), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h7777, 1'b1, 1'b1);
        check("full_pp_count", 32'(fifo_count), 32'd8);
        check("full_pp_drop",  32'(overflow_drop), 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Stuck detection: four identical valid words
        load(16'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        check("stuck_set", 32'(stuck), 32'd1);
        cycle(1'b1, 1'b0, 16'h0101, 1'b1, 1'b1);
        check("stuck_sticky", 32'(stuck), 32'd1);
        load(16'd0);
        check("stuck_clear", 32'(stuck), 32'd0);

        // Randomized traffic with random limits
        for (int blk = 0; blk < 24; blk++) begin
            case (blk % 4)
                0:       load(16'($urandom_range(2, 300)));
                1:       load(16'($urandom_range(0, 65535)));
                2:       load(16'($urandom_range(0, 1)));
                default: load(16'($urandom_range(1, 20)));
            endcase
            for (int i = 0; i < 16; i++) begin
                cycle(1'b1, ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 5) == 0) ? m_prev : 16'($urandom_range(0, 65535)),
                      ($urandom_range(0, 4) != 0), ($urandom_range(0, 1) == 1));
            end
        end

        // Reset mid-run with 5 entries buffered; nothing resumes without a new load
        load(16'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'(16'h4000 + i), 1'b1, 1'b0);
        check("pre_rst_count", 32'(fifo_count), 32'd5);
        cycle(1'b0, 1'b0, 16'h4444, 1'b1, 1'b0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 16'(16'h5000 + i), 1'b1, 1'b1);
            check("idle_no_out", 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
